// File: rtl/outdata_deorder.sv
// Frame de-interleaver: words arriving in group-interleaved order are written to a
// ping-pong buffer at their linear address, then read out 0..FRAME-1 under out_ready.
module outdata_deorder #(
  parameter int DATA_W = 24,
  parameter int GROUPS = 4,
  parameter int STEP   = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_en,
  output logic [DATA_W-1:0] outdata,
  output logic              out_sof,
  output logic              out_eof,
  output logic              overflow,
  output logic              frame_err,
  output logic              dbg_state
);

  localparam int FRAME = GROUPS * STEP;
  localparam int A_W   = $clog2(FRAME);
  localparam int G_W   = $clog2(GROUPS);
  localparam logic [A_W-1:0] LAST_IDX = A_W'(FRAME - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rd_state_t;

  // Bank b occupies mem[b*FRAME +: FRAME]; the bank select is the address MSB.
  logic [DATA_W-1:0] mem [0:2*FRAME-1];

  rd_state_t      state, state_nxt;
  logic [A_W-1:0] k, k_eff;
  logic [A_W-1:0] r, r_nxt;
  logic           wr_bank, rd_bank, rd_bank_nxt;
  logic [1:0]     bank_full, bank_full_nxt;
  logic           issue, rd_last;
  logic           wr_blocked, accept, wr_last;
  logic [A_W:0]   wr_addr;

  // Handshake: out_ready sampled in cycle n issues a read; out_en/outdata appear in
  // cycle n+1 and must be consumed there. Input has no backpressure.
  assign issue   = (state == DRAIN) && out_ready;
  assign rd_last = issue && (r == LAST_IDX);

  // A bank being released by its final read this cycle may already take a new word,
  // so a continuously drained stream never overflows at the bank hand-over.
  assign wr_blocked = bank_full[wr_bank] && !(rd_last && (rd_bank == wr_bank));
  assign accept     = in_valid && !wr_blocked;
  assign k_eff      = in_sof ? '0 : k;
  assign wr_last    = accept && (k_eff == LAST_IDX);
  assign wr_addr    = {wr_bank, k_eff[G_W-1:0], k_eff[A_W-1:G_W]};

  assign dbg_state = state;

  always_comb begin
    state_nxt   = state;
    r_nxt       = r;
    rd_bank_nxt = rd_bank;
    case (state)
      IDLE: begin
        if (bank_full[rd_bank]) begin
          state_nxt = DRAIN;
          r_nxt     = '0;
        end
      end
      DRAIN: begin
        if (issue) begin
          r_nxt = r + 1'b1;
          if (rd_last) begin
            rd_bank_nxt = ~rd_bank;
            r_nxt       = '0;
            state_nxt   = bank_full[~rd_bank] ? DRAIN : IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear and set never hit the same bank: a set needs an unfilled write bank,
  // a clear needs a full read bank.
  always_comb begin
    bank_full_nxt = bank_full;
    if (rd_last) bank_full_nxt[rd_bank] = 1'b0;
    if (wr_last) bank_full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      r         <= '0;
      rd_bank   <= 1'b0;
      k         <= '0;
      wr_bank   <= 1'b0;
      bank_full <= 2'b00;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      out_en    <= 1'b0;
      outdata   <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      state     <= state_nxt;
      r         <= r_nxt;
      rd_bank   <= rd_bank_nxt;
      bank_full <= bank_full_nxt;
      overflow  <= overflow | (in_valid && wr_blocked);
      frame_err <= in_valid && in_sof && (k != '0);
      if (accept) begin
        k <= wr_last ? '0 : k_eff + 1'b1;
        if (wr_last) wr_bank <= ~wr_bank;
      end
      out_en  <= issue;
      out_sof <= issue && (r == '0);
      out_eof <= rd_last;
      if (issue) outdata <= mem[{rd_bank, r}];
    end
  end

endmodule
